alu_bank_responder: RTL and testbench

Responder end of the four-bank ALU command/response interface. It accepts `input_packet_t` commands independently on each of four banks, executes ADD/SUB/SHL with a fixed per-command latency of 3–5 cycles, and returns an `output_packet_t` result with a one-cycle response pulse. It sits in the same position the bench's initiator drives: it consumes `input_packet[3:0]` and produces `output_packet[3:0]`.

---
 rtl/alu_bank_responder_pkg.sv | 29 ++
 rtl/alu_bank_responder_if.sv | 14 +
 rtl/alu_bank_responder.sv | 139 +++++++++++++
 tb/tb_alu_bank_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_bank_responder_pkg.sv
// Shared command/response types for the four-bank ALU interface.
package alu_bank_responder_pkg;

    typedef enum logic [1:0] {
        CMD_NOP = 2'd0,
        CMD_ADD = 2'd1,
        CMD_SUB = 2'd2,
        CMD_SHL = 2'd3
    } command_t;

    typedef enum logic [1:0] {
        RSP_NONE     = 2'd0,
        RSP_SUCCESS  = 2'd1,
        RSP_OVERFLOW = 2'd2,
        RSP_INVALID  = 2'd3
    } response_t;

    typedef struct packed {
        command_t    command;
        logic [31:0] data1;
        logic [31:0] data2;
    } input_packet_t;

    typedef struct packed {
        logic [31:0] data;
        response_t   response;
    } output_packet_t;

endpackage

// File: rtl/alu_bank_responder_if.sv
// Per-bank command and response buses between an initiator and the responder.
interface alu_bank_responder_if
    import alu_bank_responder_pkg::*;
#(
    parameter int NUM_BANKS = 4
);

    input_packet_t  [NUM_BANKS-1:0] input_packet;
    output_packet_t [NUM_BANKS-1:0] output_packet;

    modport master (output input_packet, input output_packet);
    modport slave  (input input_packet, output output_packet);

endinterface

// File: rtl/alu_bank_responder.sv
// Four independent ALU banks: each accepts a command, runs it for a fixed
// per-opcode latency, then pulses a response with a sticky result word.
module alu_bank_responder
    import alu_bank_responder_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int ADD_LAT   = 3,
    parameter int SUB_LAT   = 4,
    parameter int SHL_LAT   = 5
) (
    input logic                 clock,
    input logic                 reset,
    alu_bank_responder_if.slave bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXEC    = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    // The counter is loaded with LAT-1 at acceptance and the result is
    // registered on the edge where it is already zero, giving exactly LAT edges.
    localparam logic [2:0] ADD_CNT = 3'(ADD_LAT - 1);
    localparam logic [2:0] SUB_CNT = 3'(SUB_LAT - 1);
    localparam logic [2:0] SHL_CNT = 3'(SHL_LAT - 1);

    logic [1:0]  state_q [NUM_BANKS];
    logic [2:0]  cnt_q   [NUM_BANKS];
    command_t    cmd_q   [NUM_BANKS];
    logic [31:0] op1_q   [NUM_BANKS];
    logic [31:0] op2_q   [NUM_BANKS];
    output_packet_t [NUM_BANKS-1:0] out_q;

    function automatic logic [2:0] load_count(input command_t cmd);
        logic [2:0] cnt;
        cnt = ADD_CNT;
        case (cmd)
            CMD_SUB: cnt = SUB_CNT;
            CMD_SHL: cnt = SHL_CNT;
            default: cnt = ADD_CNT;
        endcase
        return cnt;
    endfunction

    function automatic output_packet_t execute(input command_t cmd,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        output_packet_t r;
        logic [32:0]    sum;
        r.data     = '0;
        r.response = RSP_INVALID;
        sum        = '0;
        case (cmd)
            CMD_ADD: begin
                sum        = {1'b0, a} + {1'b0, b};
                r.data     = sum[31:0];
                r.response = sum[32] ? RSP_OVERFLOW : RSP_SUCCESS;
            end
            CMD_SUB: begin
                r.data     = a - b;
                r.response = (b > a) ? RSP_OVERFLOW : RSP_SUCCESS;
            end
            CMD_SHL: begin
                // Shift amounts beyond the word width are rejected rather
                // than silently wrapped to data2[4:0].
                if (b > 32'd31) begin
                    r.data     = '0;
                    r.response = RSP_INVALID;
                end else begin
                    r.data     = a << b[4:0];
                    r.response = RSP_SUCCESS;
                end
            end
            default: begin
                r.data     = '0;
                r.response = RSP_INVALID;
            end
        endcase
        return r;
    endfunction

    // Per-bank FSM: accept in IDLE/RESPOND, count down in EXEC, pulse in RESPOND.
    // NOTE: every piece of bank state is reset, not only the FSM, because the
    // outputs must read zero asynchronously and no stale operand may leak out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= IDLE;
                cnt_q[b]   <= '0;
                cmd_q[b]   <= CMD_NOP;
                op1_q[b]   <= '0;
                op2_q[b]   <= '0;
                out_q[b]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every bank's next state a
            // function of this edge's values only, independent of loop order.
            for (int b = 0; b < NUM_BANKS; b++) begin
                case (state_q[b])
                    IDLE: begin
                        if (bus.input_packet[b].command != CMD_NOP) begin
                            cmd_q[b]   <= bus.input_packet[b].command;
                            op1_q[b]   <= bus.input_packet[b].data1;
                            op2_q[b]   <= bus.input_packet[b].data2;
                            cnt_q[b]   <= load_count(bus.input_packet[b].command);
                            state_q[b] <= EXEC;
                        end
                    end
                    EXEC: begin
                        if (cnt_q[b] == 3'd0) begin
                            out_q[b]   <= execute(cmd_q[b], op1_q[b], op2_q[b]);
                            state_q[b] <= RESPOND;
                        end else begin
                            cnt_q[b] <= cnt_q[b] - 3'd1;
                        end
                    end
                    RESPOND: begin
                        // Data stays sticky; only the response pulse ends here.
                        out_q[b].response <= RSP_NONE;
                        if (bus.input_packet[b].command != CMD_NOP) begin
                            cmd_q[b]   <= bus.input_packet[b].command;
                            op1_q[b]   <= bus.input_packet[b].data1;
                            op2_q[b]   <= bus.input_packet[b].data2;
                            cnt_q[b]   <= load_count(bus.input_packet[b].command);
                            state_q[b] <= EXEC;
                        end else begin
                            state_q[b] <= IDLE;
                        end
                    end
                    default: begin
                        state_q[b] <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.output_packet = out_q;

endmodule

// File: tb/tb_alu_bank_responder.sv
// Directed bench for alu_bank_responder: vector table plus hand-written
// sequences for reset, concurrency, input isolation and held commands.
module tb_alu_bank_responder;
    import alu_bank_responder_pkg::*;

    localparam int NB = 4;

    typedef struct {
        int          bank;
        command_t    cmd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] exp_data;
        response_t   exp_resp;
    } vec_t;

    logic clock;
    logic reset;
    int   total;
    int   passed;
    logic [31:0] prev_data [NB];
    vec_t vecs [12];

    alu_bank_responder_if #(.NUM_BANKS(NB)) bus ();

    alu_bank_responder #(
        .NUM_BANKS(NB),
        .ADD_LAT  (3),
        .SUB_LAT  (4),
        .SHL_LAT  (5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic int lat_of(input command_t cmd);
        case (cmd)
            CMD_ADD: return 3;
            CMD_SUB: return 4;
            CMD_SHL: return 5;
            default: return 0;
        endcase
    endfunction

    task automatic drive(input int b, input command_t c, input logic [31:0] d1, input logic [31:0] d2);
        bus.input_packet[b] = '{command: c, data1: d1, data2: d2};
    endtask

    task automatic all_nop();
        for (int b = 0; b < NB; b++) drive(b, CMD_NOP, 32'h0, 32'h0);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b0;
        all_nop();
        for (int b = 0; b < NB; b++) prev_data[b] = 32'h0;

        vecs[0]  = '{0, CMD_ADD, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, RSP_SUCCESS};
        vecs[1]  = '{0, CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, RSP_OVERFLOW};
        vecs[2]  = '{0, CMD_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, RSP_SUCCESS};
        vecs[3]  = '{1, CMD_SUB, 32'h0000_0010, 32'h0000_0001, 32'h0000_000F, RSP_SUCCESS};
        vecs[4]  = '{1, CMD_SUB, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, RSP_OVERFLOW};
        vecs[5]  = '{1, CMD_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, RSP_SUCCESS};
        vecs[6]  = '{2, CMD_SHL, 32'h0000_0003, 32'h0000_0004, 32'h0000_0030, RSP_SUCCESS};
        vecs[7]  = '{2, CMD_SHL, 32'h0000_0003, 32'h0000_0020, 32'h0000_0000, RSP_INVALID};
        vecs[8]  = '{2, CMD_SHL, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, RSP_SUCCESS};
        vecs[9]  = '{2, CMD_SHL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, RSP_SUCCESS};
        vecs[10] = '{3, CMD_SUB, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, RSP_OVERFLOW};
        vecs[11] = '{3, CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, RSP_OVERFLOW};

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        for (int b = 0; b < NB; b++)
            check($sformatf("reset_out_b%0d", b), 32'(bus.output_packet[b]), 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // Table-driven single-bank vectors: early, exact and trailing edge.
        for (int i = 0; i < 12; i++) begin
            int b;
            int lat;
            b   = vecs[i].bank;
            lat = lat_of(vecs[i].cmd);
            @(negedge clock);
            drive(b, vecs[i].cmd, vecs[i].d1, vecs[i].d2);
            @(posedge clock);
            @(negedge clock);
            drive(b, CMD_NOP, 32'h0, 32'h0);
            for (int k = 1; k <= lat + 1; k++) begin
                @(posedge clock);
                #1;
                if (k == lat - 1) begin
                    check($sformatf("v%0d_early_resp", i), 32'(bus.output_packet[b].response), 32'(RSP_NONE));
                    check($sformatf("v%0d_early_data", i), bus.output_packet[b].data, prev_data[b]);
                end else if (k == lat) begin
                    check($sformatf("v%0d_resp", i), 32'(bus.output_packet[b].response), 32'(vecs[i].exp_resp));
                    check($sformatf("v%0d_data", i), bus.output_packet[b].data, vecs[i].exp_data);
                end else if (k == lat + 1) begin
                    check($sformatf("v%0d_pulse_end", i), 32'(bus.output_packet[b].response), 32'(RSP_NONE));
                    check($sformatf("v%0d_sticky", i), bus.output_packet[b].data, vecs[i].exp_data);
                end
            end
            prev_data[b] = vecs[i].exp_data;
        end

        // Concurrency and input isolation: bank 0 operands change during EXEC.
        begin
            logic [31:0] exp_d [NB];
            int          lat_b [NB];
            exp_d = '{32'd30, 32'd5, 32'd8, 32'd300};
            lat_b = '{3, 4, 5, 3};
            @(negedge clock);
            drive(0, CMD_ADD, 32'd10, 32'd20);
            drive(1, CMD_SUB, 32'd9, 32'd4);
            drive(2, CMD_SHL, 32'd1, 32'd3);
            drive(3, CMD_ADD, 32'd100, 32'd200);
            @(posedge clock);
            @(negedge clock);
            all_nop();
            drive(0, CMD_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            @(negedge clock);
            drive(0, CMD_SUB, 32'd7, 32'd9);
            @(negedge clock);
            drive(0, CMD_NOP, 32'h0, 32'h0);
            // Already one edge past T+2; loop covers T+3..T+6.
            for (int k = 3; k <= 6; k++) begin
                @(posedge clock);
                #1;
                for (int b = 0; b < NB; b++) begin
                    check($sformatf("conc_k%0d_b%0d_resp", k, b), 32'(bus.output_packet[b].response),
                          (k == lat_b[b]) ? 32'(RSP_SUCCESS) : 32'(RSP_NONE));
                    if (k >= lat_b[b])
                        check($sformatf("conc_k%0d_b%0d_data", k, b), bus.output_packet[b].data, exp_d[b]);
                end
            end
        end

        // Reset mid-operation clears outputs at once; no late response.
        @(negedge clock);
        for (int b = 0; b < NB; b++) drive(b, CMD_ADD, 32'd1, 32'd2);
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        for (int b = 0; b < NB; b++)
            check($sformatf("async_clear_b%0d", b), 32'(bus.output_packet[b]), 32'h0);
        @(negedge clock);
        all_nop();
        @(negedge clock);
        reset = 1'b1;
        begin
            logic [NB-1:0] seen;
            seen = '0;
            for (int k = 0; k < 8; k++) begin
                @(posedge clock);
                #1;
                for (int b = 0; b < NB; b++)
                    if (bus.output_packet[b] != '0) seen[b] = 1'b1;
            end
            check("no_late_response", 32'(seen), 32'h0);
        end

        // Held ADD 1+1 on bank 3 re-executes every 4 cycles.
        @(negedge clock);
        drive(3, CMD_ADD, 32'd1, 32'd1);
        @(posedge clock);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("held_k%0d_resp", k), 32'(bus.output_packet[3].response),
                  (k % 4 == 3) ? 32'(RSP_SUCCESS) : 32'(RSP_NONE));
            check($sformatf("held_k%0d_data", k), bus.output_packet[3].data,
                  (k >= 3) ? 32'd2 : 32'd0);
        end
        @(negedge clock);
        all_nop();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
